ocl_cfg_demux: RTL
==================

Name: ocl_cfg_demux

Overview:
- Parametrised AXI-Lite slave that converts OCL BAR accesses into one-cycle cfg-bus request pulses toward NUM_SLV register windows.
- Successor to the fixed 16-window OCL decoder: slave count and window size are set by parameters; rd/wr arbitration is fair; unmapped windows return DECERR; wstrb is forwarded; an optional ack timeout is available.
- Sits between the OCL register slice and the CL register blocks (PCIM, AXI master, interrupt test, etc.).

Parameters:
- NUM_SLV, 6, number of cfg-bus slaves; legal range 1..2**SEL_W.
- SEL_LSB, 8, lowest address bit of the slave selector (window size = 2**SEL_LSB bytes).
- SEL_W, 4, selector width; selector = addr[SEL_LSB +: SEL_W].
- DEFAULT_RDATA, 32'hdead_beef, rdata returned on decode error or timeout.
- TIMEOUT_CYCLES, 256, ack wait limit; used only with CFG_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- sync_rst  in  1  synchronous active-high reset
- s_awaddr  in  32  write address
- s_awvalid / s_awready  in / out  1  AW handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  write strobes
- s_wvalid / s_wready  in / out  1  W handshake
- s_bresp  out  2  write response
- s_bvalid / s_bready  out / in  1  B handshake
- s_araddr  in  32  read address
- s_arvalid / s_arready  in / out  1  AR handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid / s_rready  out / in  1  R handshake
- cfg_addr_o  out  NUM_SLV*32  per-slave address (replicated copy per slave)
- cfg_wdata_o  out  NUM_SLV*32  per-slave write data
- cfg_wstrb_o  out  NUM_SLV*4  per-slave write strobes
- cfg_wr_o  out  NUM_SLV  one-cycle write pulse
- cfg_rd_o  out  NUM_SLV  one-cycle read pulse
- cfg_ack_i  in  NUM_SLV  per-slave completion
- cfg_rdata_i  in  NUM_SLV*32  per-slave read data; valid with ack

Behaviour:
- Reset (sync_rst high at posedge):
  - State = IDLE.
  - All ready, valid, cfg_wr_o and cfg_rd_o = 0.
  - cfg_addr_o, cfg_wdata_o, cfg_wstrb_o, s_rdata = 0.
  - bresp = rresp = 0; last_wr = 0.
  - Reset mid-transaction abandons the transaction with no response; an ack arriving after reset is ignored.
- States: IDLE, WDATA, ISSUE, WAIT_ACK, RESP.
- IDLE:
  - s_awready = grant_wr; s_arready = grant_rd (combinational, only in IDLE).
  - When both awvalid and arvalid are high, grant the type opposite to last_wr. Otherwise grant whichever is valid.
  - On AW handshake: latch addr, set last_wr = 1, go to WDATA.
  - On AR handshake: latch addr, set last_wr = 0, go to ISSUE.
- WDATA: s_wready = 1. On wvalid, latch wdata and wstrb, then go to ISSUE.
- ISSUE (1 cycle):
  - sel >= NUM_SLV: no pulse; resp = 2'b11 (DECERR); rdata = DEFAULT_RDATA; go to RESP.
  - Otherwise: cfg_wr_o[sel] or cfg_rd_o[sel] = 1 for exactly this cycle.
    - ack[sel] this cycle: capture rdata and go to RESP.
    - No ack: go to WAIT_ACK.
- WAIT_ACK: on cfg_ack_i[sel], capture cfg_rdata_i[sel] (reads only), set resp = 2'b00, go to RESP.
- Ack handling:
  - Acks on non-selected slaves are ignored.
  - Acks in IDLE, WDATA or RESP are ignored.
- RESP:
  - bvalid (write) or rvalid (read) held high until the matching ready is high; then go to IDLE.
  - s_rdata and resp remain stable while valid is high.
- Address handling:
  - cfg_addr_o carries the full 32-bit latched address.
  - Bits above SEL_LSB+SEL_W are ignored for decode.
- cfg_addr_o, cfg_wdata_o and cfg_wstrb_o update on handshake and hold until the next handshake.
- Minimum latency:
  - Read: AR handshake at cycle 0, rd pulse at cycle 1, ack at cycle 1 allowed, rvalid at cycle 2.
  - Write: AW handshake at cycle 0, W handshake at cycle 1, wr pulse at cycle 2, bvalid at cycle 3.
- Only one transaction is outstanding at a time.

Optional Feature:
- Macro: CFG_TIMEOUT_EN.
- With macro defined:
  - A counter clears on entry to ISSUE and increments each cycle in WAIT_ACK.
  - At TIMEOUT_CYCLES cycles since the pulse with no ack: resp = 2'b10 (SLVERR), rdata = DEFAULT_RDATA, go to RESP.
  - An ack arriving in the same cycle as the timeout wins (OKAY).
- Without macro: WAIT_ACK waits indefinitely and no counter logic is present.

Test Plan:
- Read at 0x0000_0504, slave 5 acks in the pulse cycle with rdata 0x1234_5678 -> cfg_rd_o = 6'b100000 for one cycle; rvalid at cycle 2; rdata = 0x1234_5678; rresp = 0.
- Write 0x0000_0010 / data 0xCAFE_F00D / wstrb 4'b0011, slave 0 acks 3 cycles after the pulse -> cfg_wr_o[0] pulses once; cfg_wdata_o[31:0] = 0xCAFE_F00D; cfg_wstrb_o[3:0] = 4'b0011; bresp = 0; bvalid held while bready = 0 for 4 cycles.
- Read at 0x0000_0A00 (sel 10 >= 6) -> no cfg pulse; rresp = 2'b11; rdata = 0xDEAD_BEEF.
- awvalid and arvalid held high together for 4 transactions after reset -> grant order W, R, W, R.
- With CFG_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave 1 never acks -> rresp = 2'b10 and rdata = 0xDEAD_BEEF after 8 wait cycles. A late ack then arrives in IDLE and the next transaction is unaffected.
- sync_rst asserted in WAIT_ACK -> next cycle all valids and pulses are 0, state is IDLE; a subsequent read completes normally.

Source files
------------

// File: rtl/ocl_cfg_demux.sv
// AXI-Lite slave that turns OCL BAR accesses into one-cycle cfg-bus pulses toward NUM_SLV windows.
// Optional ack timeout is compiled in with `define CFG_TIMEOUT_EN.
module ocl_cfg_demux #(
  parameter int unsigned NUM_SLV        = 6,
  parameter int unsigned SEL_LSB        = 8,
  parameter int unsigned SEL_W          = 4,
  parameter logic [31:0] DEFAULT_RDATA  = 32'hdead_beef,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   sync_rst,
  input  logic [31:0]            s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [31:0]            s_wdata,
  input  logic [3:0]             s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [31:0]            s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [31:0]            s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [NUM_SLV*32-1:0]  cfg_addr_o,
  output logic [NUM_SLV*32-1:0]  cfg_wdata_o,
  output logic [NUM_SLV*4-1:0]   cfg_wstrb_o,
  output logic [NUM_SLV-1:0]     cfg_wr_o,
  output logic [NUM_SLV-1:0]     cfg_rd_o,
  input  logic [NUM_SLV-1:0]     cfg_ack_i,
  input  logic [NUM_SLV*32-1:0]  cfg_rdata_i
);

  typedef enum logic [2:0] {StIdle, StWdata, StIssue, StWaitAck, StResp} state_e;

  localparam logic [SEL_W:0] NumSlvW = (SEL_W + 1)'(NUM_SLV);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              is_wr_q, is_wr_d;
  logic              last_wr_q, last_wr_d;

  logic [SEL_W-1:0]  sel;
  logic              decerr;
  logic              ack_sel;
  logic [31:0]       rdata_sel;
  logic              grant_wr, grant_rd;
  logic              timeout;

  assign sel    = addr_q[SEL_LSB +: SEL_W];
  assign decerr = ({1'b0, sel} >= NumSlvW);

  // Loop-based select keeps out-of-range selectors from indexing past NUM_SLV.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    cfg_wr_o  = '0;
    cfg_rd_o  = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (sel == SEL_W'(i)) begin
        ack_sel   = cfg_ack_i[i];
        rdata_sel = cfg_rdata_i[i*32 +: 32];
        if (state_q == StIssue) begin
          cfg_wr_o[i] = is_wr_q;
          cfg_rd_o[i] = ~is_wr_q;
        end
      end
    end
  end

  // On contention, alternate against the type last granted.
  assign grant_wr = s_awvalid & (~s_arvalid | ~last_wr_q);
  assign grant_rd = s_arvalid & (~s_awvalid | last_wr_q);

`ifdef CFG_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign cnt_d   = (state_q == StWaitAck) ? cnt_q + 1'b1 : '0;
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout               = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    is_wr_d   = is_wr_q;
    last_wr_d = last_wr_q;
    s_awready = 1'b0;
    s_arready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_rvalid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        s_awready = grant_wr;
        s_arready = grant_rd;
        if (grant_wr) begin
          addr_d    = s_awaddr;
          is_wr_d   = 1'b1;
          last_wr_d = 1'b1;
          state_d   = StWdata;
        end else if (grant_rd) begin
          addr_d    = s_araddr;
          is_wr_d   = 1'b0;
          last_wr_d = 1'b0;
          state_d   = StIssue;
        end
      end
      StWdata: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          wdata_d = s_wdata;
          wstrb_d = s_wstrb;
          state_d = StIssue;
        end
      end
      StIssue, StWaitAck: begin
        if (state_q == StIssue && decerr) begin
          resp_d  = 2'b11;
          rdata_d = DEFAULT_RDATA;
          state_d = StResp;
        end else if (ack_sel) begin
          resp_d  = 2'b00;
          if (!is_wr_q) rdata_d = rdata_sel;
          state_d = StResp;
        end else if (state_q == StWaitAck && timeout) begin
          resp_d  = 2'b10;
          rdata_d = DEFAULT_RDATA;
          state_d = StResp;
        end else begin
          state_d = StWaitAck;
        end
      end
      StResp: begin
        s_bvalid = is_wr_q;
        s_rvalid = ~is_wr_q;
        if (is_wr_q ? s_bready : s_rready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      is_wr_q   <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      is_wr_q   <= is_wr_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign cfg_addr_o  = {NUM_SLV{addr_q}};
  assign cfg_wdata_o = {NUM_SLV{wdata_q}};
  assign cfg_wstrb_o = {NUM_SLV{wstrb_q}};
  assign s_rdata     = rdata_q;
  assign s_bresp     = resp_q;
  assign s_rresp     = resp_q;

endmodule
